mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
Multicycle MIPS control unit: a Moore FSM plus ALU decoder driving a shared-memory multicycle datapath (IR, A/B, ALUOut, Data registers; single unified memory). It generalises the single-cycle controller with memory wait-state handshaking and parametrised ISA extensions (BNE, SLTI, ANDI, ORI). It also adds a sticky illegal-instruction trap. It sits beside the multicycle datapath inside the multicycle mips top.

Parameters:
EXT_OPS, 1, 1 = BNE/SLTI/ANDI/ORI decoded; 0 = those opcodes trap as illegal
ALUCTRL_W, 3, alucontrol width (codes below occupy the low 3 bits; upper bits 0)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
op  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
iord  out  1  0 = address from PC, 1 = address from ALUOut
memwrite  out  1  memory write strobe, valid with mem_req
irwrite  out  1  load instruction register
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = Data register, 0 = ALUOut
regwrite  out  1  register-file write enable
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 B, 01 const 4, 10 SignImm/ZeroImm, 11 SignImm<<2
immext  out  1  1 = zero-extend immediate (ANDI/ORI)
pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
pcen  out  1  PC register enable
alucontrol  out  ALUCTRL_W  add 010, sub 110, and 000, or 001, slt 111
illegal  out  1  sticky trap flag

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BRANCHEX, IMMEX, IMMWB, JEX, TRAP. Unlisted outputs are 0 in each state.
- Reset asserted: state = FETCH, illegal = 0, all outputs forced to 0. Reset asserted mid-access aborts the access. After release, the first cycle is FETCH.
- FETCH: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, alucontrol = add, pcsrc = 00. irwrite and pcen = mem_ready. The state holds while mem_ready = 0, then goes to DECODE.
- DECODE: alusrca = 0, alusrcb = 11, alucontrol = add; branch target goes to ALUOut. The FSM samples op:
  - LW/SW (100011/101011) -> MEMADR
  - R-type (000000) -> RTYPEEX
  - BEQ (000100) -> BRANCHEX
  - ADDI (001000) -> IMMEX
  - J (000010) -> JEX
  - EXT_OPS = 1: BNE 000101 -> BRANCHEX; SLTI 001010, ANDI 001100, ORI 001101 -> IMMEX
  - Any other op -> TRAP
- MEMADR: alusrca = 1, alusrcb = 10, alucontrol = add. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req = 1, iord = 1. Holds until mem_ready, then MEMWB.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1, then FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = 1, both held stable until mem_ready. On mem_ready, goes to FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00. alucontrol comes from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Recognised funct -> RTYPEWB; unrecognised -> TRAP with no register write.
- RTYPEWB: regdst = 1, memtoreg = 0, regwrite = 1, then FETCH.
- BRANCHEX: alusrca = 1, alusrcb = 00, alucontrol = sub, pcsrc = 01. pcen = zero for BEQ, ~zero for BNE (op[0] selects). Then FETCH.
- IMMEX: alusrca = 1, alusrcb = 10. Per op: ADDI add, SLTI slt, ANDI and, ORI or. immext = 1 only for ANDI/ORI. Then IMMWB.
- IMMWB: regdst = 0, memtoreg = 0, regwrite = 1, then FETCH.
- JEX: pcsrc = 10, pcen = 1, then FETCH.
- TRAP: all writes and mem_req are 0, illegal = 1. The state is held until reset.
- Zero-wait latencies (add one cycle per mem_ready = 0 cycle in FETCH/MEMRD/MEMWR): LW 5, SW 4, R-type 4, immediate ops 4, BEQ/BNE 3, J 3.
- pcen never asserts in the same cycle as regwrite or memwrite.

Decomposition:
- Package mips_mc_pkg holds:
  - statetype enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_J)
  - funct constants
  - ALU_ADD/SUB/AND/OR/SLT codes
- One sub-module, mc_aludec: combinational funct/op to alucontrol, with a valid flag used for the trap.

Test Plan:
- Reset low mid-MEMRD with mem_ready = 0 -> all outputs 0 immediately. After release: FETCH, mem_req = 1, iord = 0.
- LW, mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles); regwrite = 1 with memtoreg = 1 only in cycle 5.
- FETCH with mem_ready low for 3 cycles -> irwrite/pcen = 0 for 3 cycles, 1 on the 4th, then DECODE.
- BNE with zero = 0 -> pcen = 1, pcsrc = 01 in BRANCHEX. BNE with zero = 1 -> pcen = 0. BEQ shows the opposite.
- ORI (EXT_OPS = 1) -> IMMEX: alucontrol = 001, immext = 1, alusrcb = 10; IMMWB: regwrite = 1, regdst = 0. Same ORI with EXT_OPS = 0 -> TRAP, illegal = 1, no regwrite.
- R-type funct 000111 -> TRAP after RTYPEEX. illegal stays 1 for 20 cycles of arbitrary stimulus and clears only on reset.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: FSM states,
// opcode/funct constants, ALU control codes and the control-word bundle.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPEEX  = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCHEX = 4'd8,
    IMMEX    = 4'd9,
    IMMWB    = 4'd10,
    JEX      = 4'd11,
    TRAP     = 4'd12
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immext;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alu;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Opcodes that only decode when the ISA extensions are enabled.
  function automatic logic is_ext_op(input logic [5:0] op);
    return (op == OP_BNE) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_mc_controller_aludec.sv
// Combinational ALU decoder: funct -> alucontrol for R-type (with a validity
// flag feeding the trap) and op -> alucontrol/zero-extend for immediate ops.
module mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_r,
  output logic       r_valid,
  output logic [2:0] alu_i,
  output logic       i_zext
);

  always_comb begin
    alu_r   = ALU_ADD;
    r_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_r = ALU_ADD;
      FN_SUB:  alu_r = ALU_SUB;
      FN_AND:  alu_r = ALU_AND;
      FN_OR:   alu_r = ALU_OR;
      FN_SLT:  alu_r = ALU_SLT;
      default: begin
        alu_r   = ALU_ADD;
        r_valid = 1'b0;
      end
    endcase
  end

  // Logical immediates zero-extend; arithmetic ones sign-extend.
  always_comb begin
    alu_i  = ALU_ADD;
    i_zext = 1'b0;
    case (op)
      OP_SLTI: alu_i = ALU_SLT;
      OP_ANDI: begin
        alu_i  = ALU_AND;
        i_zext = 1'b1;
      end
      OP_ORI: begin
        alu_i  = ALU_OR;
        i_zext = 1'b1;
      end
      default: begin
        alu_i  = ALU_ADD;
        i_zext = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM with memory wait-state handshake,
// optional BNE/SLTI/ANDI/ORI decode and a sticky illegal-instruction trap.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int EXT_OPS   = 1,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 immext,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
);

  localparam logic EXT_EN = (EXT_OPS != 0);

  statetype   state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] alu_r_s, alu_i_s;
  logic       r_valid_s, i_zext_s;
  ctrl_t      ctrl_s, ctrl_o_s;

  mc_aludec u_aludec (
    .op      (op),
    .funct   (funct),
    .alu_r   (alu_r_s),
    .r_valid (r_valid_s),
    .alu_i   (alu_i_s),
    .i_zext  (i_zext_s)
  );

  // State and sticky trap flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else           state_d = FETCH;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BRANCHEX;
          OP_ADDI:      state_d = IMMEX;
          OP_J:         state_d = JEX;
          OP_BNE: begin
            if (EXT_EN) state_d = BRANCHEX;
            else        state_d = TRAP;
          end
          OP_SLTI, OP_ANDI, OP_ORI: begin
            if (EXT_EN) state_d = IMMEX;
            else        state_d = TRAP;
          end
          default: state_d = TRAP;
        endcase
      end
      MEMADR: begin
        if (op == OP_SW) state_d = MEMWR;
        else             state_d = MEMRD;
      end
      MEMRD: begin
        if (mem_ready) state_d = MEMWB;
        else           state_d = MEMRD;
      end
      MEMWR: begin
        if (mem_ready) state_d = FETCH;
        else           state_d = MEMWR;
      end
      RTYPEEX: begin
        if (r_valid_s) state_d = RTYPEWB;
        else           state_d = TRAP;
      end
      IMMEX:                                   state_d = IMMWB;
      MEMWB, RTYPEWB, BRANCHEX, IMMWB, JEX:    state_d = FETCH;
      TRAP:                                    state_d = TRAP;
      default:                                 state_d = TRAP;
    endcase
    illegal_d = illegal_q | (state_d == TRAP);
  end

  // Moore control word per state; only the FETCH strobes and the branch
  // enable look at live inputs.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    case (state_q)
      FETCH: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.alusrcb = 2'b01;
        ctrl_s.alu     = ALU_ADD;
        ctrl_s.irwrite = mem_ready;
        ctrl_s.pcen    = mem_ready;
      end
      DECODE: begin
        ctrl_s.alusrcb = 2'b11;
        ctrl_s.alu     = ALU_ADD;
      end
      MEMADR: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b10;
        ctrl_s.alu     = ALU_ADD;
      end
      MEMRD: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl_s.memtoreg = 1'b1;
        ctrl_s.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl_s.mem_req  = 1'b1;
        ctrl_s.iord     = 1'b1;
        ctrl_s.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alu     = alu_r_s;
      end
      RTYPEWB: begin
        ctrl_s.regdst   = 1'b1;
        ctrl_s.regwrite = 1'b1;
      end
      BRANCHEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alu     = ALU_SUB;
        ctrl_s.pcsrc   = 2'b01;
        // op[0] distinguishes BNE (000101) from BEQ (000100).
        if (op[0]) ctrl_s.pcen = ~zero;
        else       ctrl_s.pcen = zero;
      end
      IMMEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b10;
        ctrl_s.alu     = alu_i_s;
        ctrl_s.immext  = i_zext_s;
      end
      IMMWB: begin
        ctrl_s.regwrite = 1'b1;
      end
      JEX: begin
        ctrl_s.pcsrc = 2'b10;
        ctrl_s.pcen  = 1'b1;
      end
      TRAP:    ctrl_s = CTRL_IDLE;
      default: ctrl_s = CTRL_IDLE;
    endcase
  end

  // Reset overrides the decoded word so an in-flight access drops at once.
  always_comb begin
    if (reset) ctrl_o_s = ctrl_s;
    else       ctrl_o_s = CTRL_IDLE;
  end

  assign mem_req    = ctrl_o_s.mem_req;
  assign iord       = ctrl_o_s.iord;
  assign memwrite   = ctrl_o_s.memwrite;
  assign irwrite    = ctrl_o_s.irwrite;
  assign regdst     = ctrl_o_s.regdst;
  assign memtoreg   = ctrl_o_s.memtoreg;
  assign regwrite   = ctrl_o_s.regwrite;
  assign alusrca    = ctrl_o_s.alusrca;
  assign alusrcb    = ctrl_o_s.alusrcb;
  assign immext     = ctrl_o_s.immext;
  assign pcsrc      = ctrl_o_s.pcsrc;
  assign pcen       = ctrl_o_s.pcen;
  assign alucontrol = ALUCTRL_W'(ctrl_o_s.alu);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Table-driven bench for mips_mc_controller: per-cycle expected control words
// for each instruction class, wait states, resets and the sticky trap.
module tb_mips_mc_controller;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_SLTI = 6'b001010, T_ANDI = 6'b001100, T_ORI = 6'b001101;
  localparam logic [5:0] T_J = 6'b000010, T_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_OR = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010, F_BAD = 6'b000111;
  localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000;
  localparam logic [2:0] A_OR = 3'b001, A_SLT = 3'b111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op, funct;

  logic mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic immext, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  logic mem_req0, iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0;
  logic immext0, pcen0, illegal0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;

  int n_pass = 0;
  int n_total = 0;
  vec_t tbl[$];

  logic [17:0] e_rst, e_fr, e_fw, e_dec, e_madr, e_mrd, e_mwb, e_mwr;
  logic [17:0] e_rwb, e_iwb, e_jex, e_trap;

  mips_mc_controller #(.EXT_OPS(1), .ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .immext(immext), .pcsrc(pcsrc),
    .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal)
  );

  mips_mc_controller #(.EXT_OPS(0), .ALUCTRL_W(3)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req0), .iord(iord0), .memwrite(memwrite0),
    .irwrite(irwrite0), .regdst(regdst0), .memtoreg(memtoreg0), .regwrite(regwrite0),
    .alusrca(alusrca0), .alusrcb(alusrcb0), .immext(immext0), .pcsrc(pcsrc0),
    .pcen(pcen0), .alucontrol(alucontrol0), .illegal(illegal0)
  );

  always #5 clk = ~clk;

  wire [17:0] out1 = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                      alusrca, alusrcb, immext, pcsrc, pcen, alucontrol, illegal};
  wire [17:0] out0 = {mem_req0, iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0,
                      alusrca0, alusrcb0, immext0, pcsrc0, pcen0, alucontrol0, illegal0};

  function automatic logic [17:0] mk(input logic mr, io, mw, irw, rd, mtr, rw, sa,
                                     input logic [1:0] sb, input logic ie,
                                     input logic [1:0] ps, input logic pe,
                                     input logic [2:0] al, input logic il);
    return {mr, io, mw, irw, rd, mtr, rw, sa, sb, ie, ps, pe, al, il};
  endfunction

  function automatic logic [17:0] rex(input logic [2:0] al);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, al, 1'b0);
  endfunction

  function automatic logic [17:0] bex(input logic pe);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, pe, A_SUB, 1'b0);
  endfunction

  function automatic logic [17:0] iex(input logic [2:0] al, input logic ie);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, ie, 2'b00, 1'b0, al, 1'b0);
  endfunction

  task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic rdy, input logic [17:0] e, input string nm);
    vec_t v;
    v.rst = rst; v.op = o; v.fn = f; v.z = z; v.rdy = rdy; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [17:0] act, input logic [17:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %b want %b", nm, idx, act, exp);
  endtask

  task automatic drive(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic rdy);
    @(negedge clk);
    reset = rst; op = o; funct = f; zero = z; mem_ready = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    e_rst  = 18'd0;
    e_fr   = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1, A_ADD, 1'b0);
    e_fw   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, A_ADD, 1'b0);
    e_dec  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, A_ADD, 1'b0);
    e_madr = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, A_ADD, 1'b0);
    e_mrd  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
    e_mwb  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
    e_mwr  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
    e_rwb  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
    e_iwb  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
    e_jex  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'b000, 1'b0);
    e_trap = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1);

    add(1'b0, T_LW, F_ADD, 1'b0, 1'b1, e_rst, "reset");
    // LW, zero wait: 5 cycles, write-back only in the last
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_fr,   "lw_fetch");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_dec,  "lw_decode");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_madr, "lw_memadr");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_mrd,  "lw_memrd");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_mwb,  "lw_memwb");
    add(1'b1, T_SW, F_ADD, 1'b0, 1'b1, e_fr,   "sw_fetch");
    add(1'b1, T_SW, F_ADD, 1'b0, 1'b1, e_dec,  "sw_decode");
    add(1'b1, T_SW, F_ADD, 1'b0, 1'b1, e_madr, "sw_memadr");
    add(1'b1, T_SW, F_ADD, 1'b0, 1'b0, e_mwr,  "sw_memwr_wait");
    add(1'b1, T_SW, F_ADD, 1'b0, 1'b1, e_mwr,  "sw_memwr");
    // FETCH stalled three cycles then R-type add
    for (int i = 0; i < 3; i++) add(1'b1, T_R, F_ADD, 1'b0, 1'b0, e_fw, "fetch_wait");
    add(1'b1, T_R, F_ADD, 1'b0, 1'b1, e_fr,        "fetch_go");
    add(1'b1, T_R, F_ADD, 1'b0, 1'b1, e_dec,       "add_decode");
    add(1'b1, T_R, F_ADD, 1'b0, 1'b1, rex(A_ADD),  "add_ex");
    add(1'b1, T_R, F_ADD, 1'b0, 1'b1, e_rwb,       "add_wb");
    add(1'b1, T_R, F_SUB, 1'b0, 1'b1, e_fr,        "sub_fetch");
    add(1'b1, T_R, F_SUB, 1'b0, 1'b1, e_dec,       "sub_decode");
    add(1'b1, T_R, F_SUB, 1'b0, 1'b1, rex(A_SUB),  "sub_ex");
    add(1'b1, T_R, F_SUB, 1'b0, 1'b1, e_rwb,       "sub_wb");
    add(1'b1, T_R, F_OR,  1'b0, 1'b1, e_fr,        "or_fetch");
    add(1'b1, T_R, F_OR,  1'b0, 1'b1, e_dec,       "or_decode");
    add(1'b1, T_R, F_OR,  1'b0, 1'b1, rex(A_OR),   "or_ex");
    add(1'b1, T_R, F_OR,  1'b0, 1'b1, e_rwb,       "or_wb");
    add(1'b1, T_R, F_SLT, 1'b0, 1'b1, e_fr,        "slt_fetch");
    add(1'b1, T_R, F_SLT, 1'b0, 1'b1, e_dec,       "slt_decode");
    add(1'b1, T_R, F_SLT, 1'b0, 1'b1, rex(A_SLT),  "slt_ex");
    add(1'b1, T_R, F_SLT, 1'b0, 1'b1, e_rwb,       "slt_wb");
    // Branches: BEQ takes on zero, BNE on ~zero
    add(1'b1, T_BEQ, F_ADD, 1'b1, 1'b1, e_fr,      "beq1_fetch");
    add(1'b1, T_BEQ, F_ADD, 1'b1, 1'b1, e_dec,     "beq1_decode");
    add(1'b1, T_BEQ, F_ADD, 1'b1, 1'b1, bex(1'b1), "beq_z1");
    add(1'b1, T_BEQ, F_ADD, 1'b0, 1'b1, e_fr,      "beq0_fetch");
    add(1'b1, T_BEQ, F_ADD, 1'b0, 1'b1, e_dec,     "beq0_decode");
    add(1'b1, T_BEQ, F_ADD, 1'b0, 1'b1, bex(1'b0), "beq_z0");
    add(1'b1, T_BNE, F_ADD, 1'b0, 1'b1, e_fr,      "bne0_fetch");
    add(1'b1, T_BNE, F_ADD, 1'b0, 1'b1, e_dec,     "bne0_decode");
    add(1'b1, T_BNE, F_ADD, 1'b0, 1'b1, bex(1'b1), "bne_z0");
    add(1'b1, T_BNE, F_ADD, 1'b1, 1'b1, e_fr,      "bne1_fetch");
    add(1'b1, T_BNE, F_ADD, 1'b1, 1'b1, e_dec,     "bne1_decode");
    add(1'b1, T_BNE, F_ADD, 1'b1, 1'b1, bex(1'b0), "bne_z1");
    // Immediate ops
    add(1'b1, T_ADDI, F_ADD, 1'b0, 1'b1, e_fr,              "addi_fetch");
    add(1'b1, T_ADDI, F_ADD, 1'b0, 1'b1, e_dec,             "addi_decode");
    add(1'b1, T_ADDI, F_ADD, 1'b0, 1'b1, iex(A_ADD, 1'b0),  "addi_ex");
    add(1'b1, T_ADDI, F_ADD, 1'b0, 1'b1, e_iwb,             "addi_wb");
    add(1'b1, T_SLTI, F_ADD, 1'b0, 1'b1, e_fr,              "slti_fetch");
    add(1'b1, T_SLTI, F_ADD, 1'b0, 1'b1, e_dec,             "slti_decode");
    add(1'b1, T_SLTI, F_ADD, 1'b0, 1'b1, iex(A_SLT, 1'b0),  "slti_ex");
    add(1'b1, T_SLTI, F_ADD, 1'b0, 1'b1, e_iwb,             "slti_wb");
    add(1'b1, T_ANDI, F_ADD, 1'b0, 1'b1, e_fr,              "andi_fetch");
    add(1'b1, T_ANDI, F_ADD, 1'b0, 1'b1, e_dec,             "andi_decode");
    add(1'b1, T_ANDI, F_ADD, 1'b0, 1'b1, iex(A_AND, 1'b1),  "andi_ex");
    add(1'b1, T_ANDI, F_ADD, 1'b0, 1'b1, e_iwb,             "andi_wb");
    add(1'b1, T_ORI,  F_ADD, 1'b0, 1'b1, e_fr,              "ori_fetch");
    add(1'b1, T_ORI,  F_ADD, 1'b0, 1'b1, e_dec,             "ori_decode");
    add(1'b1, T_ORI,  F_ADD, 1'b0, 1'b1, iex(A_OR, 1'b1),   "ori_ex");
    add(1'b1, T_ORI,  F_ADD, 1'b0, 1'b1, e_iwb,             "ori_wb");
    add(1'b1, T_J, F_ADD, 1'b0, 1'b1, e_fr,   "j_fetch");
    add(1'b1, T_J, F_ADD, 1'b0, 1'b1, e_dec,  "j_decode");
    add(1'b1, T_J, F_ADD, 1'b0, 1'b1, e_jex,  "j_ex");
    // Reset while MEMRD is waiting on memory
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_fr,   "lw2_fetch");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_dec,  "lw2_decode");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b0, e_madr, "lw2_memadr");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b0, e_mrd,  "lw2_memrd_wait");
    add(1'b0, T_LW, F_ADD, 1'b0, 1'b0, e_rst,  "reset_mid_memrd");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b0, e_fw,   "post_reset_fetch");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_fr,   "lw3_fetch");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_dec,  "lw3_decode");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_madr, "lw3_memadr");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b0, e_mrd,  "lw3_memrd_wait");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_mrd,  "lw3_memrd");
    add(1'b1, T_LW, F_ADD, 1'b0, 1'b1, e_mwb,  "lw3_memwb");
    // Unknown opcode traps from DECODE
    add(1'b1, T_BAD, F_ADD, 1'b0, 1'b1, e_fr,   "badop_fetch");
    add(1'b1, T_BAD, F_ADD, 1'b0, 1'b1, e_dec,  "badop_decode");
    add(1'b1, T_BAD, F_ADD, 1'b0, 1'b1, e_trap, "badop_trap");
    add(1'b0, T_BAD, F_ADD, 1'b0, 1'b1, e_rst,  "badop_reset");
    // Unknown funct traps after RTYPEEX
    add(1'b1, T_R, F_BAD, 1'b0, 1'b1, e_fr,       "badfn_fetch");
    add(1'b1, T_R, F_BAD, 1'b0, 1'b1, e_dec,      "badfn_decode");
    add(1'b1, T_R, F_BAD, 1'b0, 1'b1, rex(A_ADD), "badfn_ex");
    add(1'b1, T_R, F_BAD, 1'b0, 1'b1, e_trap,     "badfn_trap");

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy);
      chk(tbl[i].name, i, out1, tbl[i].exp);
    end

    // Trap stays sticky under arbitrary stimulus until reset
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
      chk("trap_sticky", i, out1, e_trap);
    end
    drive(1'b0, T_R, F_ADD, 1'b0, 1'b1);
    chk("trap_reset", 0, out1, e_rst);
    drive(1'b1, T_R, F_ADD, 1'b0, 1'b1);
    chk("trap_release_fetch", 0, out1, e_fr);

    // EXT_OPS = 0: ORI traps from DECODE with no register write
    drive(1'b0, T_ORI, F_ADD, 1'b0, 1'b1);
    chk("ext0_reset", 0, out0, e_rst);
    drive(1'b1, T_ORI, F_ADD, 1'b0, 1'b1);
    chk("ext0_ori_fetch", 0, out0, e_fr);
    drive(1'b1, T_ORI, F_ADD, 1'b0, 1'b1);
    chk("ext0_ori_decode", 0, out0, e_dec);
    drive(1'b1, T_ORI, F_ADD, 1'b0, 1'b1);
    chk("ext0_ori_trap", 0, out0, e_trap);
    drive(1'b1, T_ORI, F_ADD, 1'b0, 1'b1);
    chk("ext0_ori_trap_hold", 0, out0, e_trap);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
